seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring divider; the inverse of the datapath's combinational multiply (A * B).
- Takes WIDTH-bit unsigned dividend and divisor on a start strobe.
- Produces one quotient bit per clock, then returns quotient and remainder with a one-cycle done pulse.
- Sits beside the ALU/accumulator register; the 2*WIDTH result packs as {remainder, quotient}, in the same layout as the 8-bit ALU result.

Parameters:
- WIDTH, 4, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  request; accepted only in IDLE
- dividend  input  WIDTH  unsigned numerator, sampled when start is accepted
- divisor  input  WIDTH  unsigned denominator, sampled when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid from this cycle on
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag for the last completed operation
- result  output  2*WIDTH  {remainder, quotient}, for the register/hex path

Behaviour:
- Reset (reset_n == 0 at the edge): state=IDLE; busy, done, div_by_zero, quotient, remainder all 0; counter and working registers 0.
- Reset has priority over every other event, including mid-RUN. An aborted operation produces no done and leaves no partial result.

State machine:
- IDLE -> RUN: on start with divisor != 0.
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits).
  - Set cnt=WIDTH.
- IDLE -> DONE: on start with divisor == 0.
  - Load quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN, each cycle:
  - {R,Q} <= {R,Q} << 1.
  - T = R_shifted - {0,D}.
  - If T is non-negative (MSB 0): R <= T and Q[0] <= 1; else R is kept and Q[0] <= 0.
  - cnt <= cnt - 1.
- RUN -> DONE: on the step where cnt == 1. On that edge, quotient <= final Q, remainder <= final R[WIDTH-1:0], div_by_zero <= 0.
- DONE -> IDLE: unconditionally after one cycle.

Outputs and timing:
- done = (state == DONE). busy = (state != IDLE).
- Latency: start accepted at edge k.
  - Normal: done is high between edges k+WIDTH and k+WIDTH+1 (WIDTH=4 gives 4 cycles).
  - Divide by zero: done is high between edges k and k+1.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE, giving a minimum period of WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; it is not queued.
- Operands are sampled only at acceptance. Later changes on dividend/divisor have no effect.
- quotient, remainder and div_by_zero hold their values until the next completion or reset. They never show intermediate values.

Arithmetic:
- Unsigned only.
- The partial remainder is WIDTH+1 bits so the subtract borrow is explicit.
- Invariant at completion: dividend == quotient*divisor + remainder, and remainder < divisor.
- Boundary cases:
  - dividend < divisor gives quotient 0, remainder = dividend.
  - dividend == 0 gives 0/0 for any nonzero divisor.
  - divisor == 1 gives quotient = dividend.

Decomposition:
- Shared constants header:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; ST 2'd3 is illegal and recovers to IDLE.
  - default WIDTH.
- One natural sub-module, div_step: combinational, takes R, Q MSB and D, and returns the next R and the quotient bit. It is reused by the bench's reference model.
- The FSM, counter and output registers live in seq_divider.

Test Plan:
- Reset, then start with 13/3 (WIDTH=4) -> busy next cycle; done exactly 4 edges after acceptance; quotient=4, remainder=1, result=8'h14, div_by_zero=0.
- 15/1 and 3/7 back-to-back, second start in the IDLE cycle after done -> results 15 r0 then 0 r3; second done 6 cycles after the first.
- 5/0 -> done one cycle after acceptance; quotient=4'hF, remainder=5, div_by_zero=1. Then 9/2 -> quotient=4, remainder=1, div_by_zero cleared.
- Start 12/5 with start held high for 8 cycles, and operands changed to 1/1 in cycle 2 -> exactly two operations: the first gives 2 r2 (original operands); the second starts in the IDLE cycle and uses 1/1, giving 1 r0.
- reset_n low for one edge in the 2nd RUN cycle of 14/3 -> next cycle state IDLE, all outputs 0, no done pulse. A following 14/3 gives 4 r2.
- Exhaustive sweep over all 256 dividend/divisor pairs -> results match div_step model and the invariant; each done is a single-cycle pulse.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM encodings and default operand width for seq_divider.
package seq_divider_pkg;
    localparam int DEF_WIDTH = 4;
    // 2'd3 is not a state; the next-state logic sends it back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division step.
// Ports: r (partial remainder, WIDTH+1), q_msb (dividend bit shifted in), d (divisor)
//        -> r_next (next partial remainder), q_bit (quotient bit produced).
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] t;
    always_comb begin
        t      = {r, q_msb} - {2'b00, d};
        q_bit  = ~t[WIDTH+1];
        r_next = q_bit ? t[WIDTH:0] : {r[WIDTH-1:0], q_msb};
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports: clk, reset_n (sync, active-low), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero, result={remainder,quotient} out.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r, r_nx;
    logic [WIDTH-1:0] q, d, q_nx;
    logic             q_bit;
    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q_msb  (q[WIDTH-1]),
        .d      (d),
        .r_next (r_nx),
        .q_bit  (q_bit)
    );
    assign q_nx        = (q << 1) | WIDTH'(q_bit);
    assign busy        = state != ST_IDLE;
    assign done        = state == ST_DONE;
    assign result      = {remainder, quotient};
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = !start ? ST_IDLE : (divisor != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  state_nx = (cnt == CW'(1)) ? ST_DONE : ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                if (divisor != '0) begin
                    q   <= dividend;
                    d   <= divisor;
                    r   <= '0;
                    cnt <= CW'(WIDTH);
                end else begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end
            if (state == ST_RUN) begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt - CW'(1);
                // Outputs only change on the final step, so they never expose partial values.
                if (cnt == CW'(1)) begin
                    quotient    <= q_nx;
                    remainder   <= r_nx[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive scoreboard bench for seq_divider (WIDTH=4).
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       reset_n, start;
    logic [3:0] dividend, divisor, quotient, remainder;
    logic       busy, done, div_by_zero;
    logic [7:0] result;
    logic [4:0] ds_r, ds_rn;
    logic       ds_qm, ds_qb;
    logic [3:0] ds_d;
    int checks = 0, errors = 0, cyc = 0, done_count = 0;
    bit prev_done = 1'b0;

    typedef struct {
        logic [3:0] a, b, q, r;
        logic       z;
    } exp_t;
    exp_t sb[$];

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    div_step #(.WIDTH(4)) u_ds (.r(ds_r), .q_msb(ds_qm), .d(ds_d), .r_next(ds_rn), .q_bit(ds_qb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.z = (b == 4'd0);
        e.q = e.z ? 4'hF : a / b;
        e.r = e.z ? a : a % b;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_count++;
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                check("result", 32'(result), 32'({e.r, e.q}));
                if (!e.z) begin
                    check("invariant_eq", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check("invariant_lt", 32'(remainder < e.b), 32'd1);
                end
            end
        end
        prev_done = done;
    end

    // Caller is at a negedge; returns at the negedge just after the acceptance edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit push);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, t1, n0;
        // div_step alone: 3,msb1 vs 5 -> 7-5=2 bit 1; 1,msb0 vs 3 -> 2 kept, bit 0
        ds_r = 5'd3; ds_qm = 1'b1; ds_d = 4'd5;
        #1;
        check("step_sub_r", 32'(ds_rn), 32'd2);
        check("step_sub_q", 32'(ds_qb), 32'd1);
        ds_r = 5'd1; ds_qm = 1'b0; ds_d = 4'd3;
        #1;
        check("step_keep_r", 32'(ds_rn), 32'd2);
        check("step_keep_q", 32'(ds_qb), 32'd0);

        reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        start_op(4'd13, 4'd3, 1'b1);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(lat);
        check("latency_normal", 32'(lat), 32'd4);
        check("result_13_3", 32'(result), 32'h14);
        @(negedge clk);

        start_op(4'd15, 4'd1, 1'b1);
        wait_done(lat);
        t1 = cyc;
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
        start_op(4'd3, 4'd7, 1'b1);
        wait_done(lat);
        check("back_to_back_period", 32'(cyc - t1), 32'd6);
        @(negedge clk);

        start_op(4'd5, 4'd0, 1'b1);
        check("latency_dbz", 32'(done), 32'd1);
        @(negedge clk);
        start_op(4'd9, 4'd2, 1'b1);
        wait_done(lat);
        check("dbz_cleared", 32'(div_by_zero), 32'd0);
        @(negedge clk);

        n0 = done_count;
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        sb.push_back(model(4'd12, 4'd5));
        @(negedge clk);
        dividend = 4'd1; divisor = 4'd1;
        sb.push_back(model(4'd1, 4'd1));
        repeat (7) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("held_start_ops", 32'(done_count - n0), 32'd2);

        start_op(4'd14, 4'd3, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        n0 = done_count;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_count - n0), 32'd0);
        start_op(4'd14, 4'd3, 1'b1);
        wait_done(lat);
        check("after_abort_result", 32'(result), 32'h24);
        @(negedge clk);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b), 1'b1);
                wait_done(lat);
                check("sweep_latency", 32'(lat), (b == 0) ? 32'd0 : 32'd4);
                @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
